// File: rtl/uart_io_switch_poller.sv
// Switch poller: periodically reads the switch PIO, debounces the sampled value
// and sends each newly accepted value to the UART TX stream as an ASCII digit.
// Optional macro UART_IO_SWITCH_POLLER_CRLF_EN: send digit, CR, LF as three beats.
module uart_io_switch_poller #(
    parameter int unsigned POLL_DIV   = 50000,
    parameter int unsigned STABLE_CNT = 4,
    parameter int unsigned SW_WIDTH   = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                poll_en,
    output logic [1:0]          pio_address,
    input  logic [31:0]         pio_readdata,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [SW_WIDTH-1:0] sw_state,
    output logic                sw_changed
);

    localparam int unsigned TimerW = $clog2(POLL_DIV);
    localparam int unsigned CntW   = $clog2(STABLE_CNT + 1);
    localparam logic [TimerW-1:0] TimerReload = TimerW'(POLL_DIV - 1);
    localparam logic [CntW-1:0]   StableMax   = CntW'(STABLE_CNT);
    localparam logic [1:0]        AddrSw      = 2'd0;
    localparam logic [1:0]        AddrIdle    = 2'd3;

    typedef enum logic [2:0] {StIdle, StAddr, StWait, StCapture, StSend} state_e;

    state_e                state_q, state_d;
    logic [TimerW-1:0]     timer_q, timer_d;
    logic                  pend_q, pend_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [SW_WIDTH-1:0]   cand_q, cand_d;
    logic [SW_WIDTH-1:0]   sw_state_q, sw_state_d;
    logic                  reported_q, reported_d;
    logic                  sw_changed_q, sw_changed_d;
    logic [1:0]            addr_q, addr_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
`ifdef UART_IO_SWITCH_POLLER_CRLF_EN
    logic [1:0]            beat_q, beat_d;
`endif

    logic [SW_WIDTH-1:0]   sample;
    logic [CntW-1:0]       cnt_upd;
    logic                  expire;
    logic                  accept;
    logic                  tx_fire;
    logic                  send_done;
    logic                  unused_rd;

    assign sample    = pio_readdata[SW_WIDTH-1:0];
    assign unused_rd = ^pio_readdata[31:SW_WIDTH];
    assign expire    = poll_en && (timer_q == '0);
    assign tx_fire   = tx_valid_q && tx_ready;

    // Debounce counter update and acceptance decision for the current sample
    always_comb begin
        if (sample == cand_q) begin
            cnt_upd = (cnt_q == StableMax) ? cnt_q : cnt_q + 1'b1;
        end else begin
            cnt_upd = CntW'(1);
        end
        accept = (cnt_upd == StableMax) && ((sample != sw_state_q) || !reported_q);
    end

    // Next-state logic for the poll sequencer, debouncer and TX handshake
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        pend_d       = pend_q;
        cnt_d        = cnt_q;
        cand_d       = cand_q;
        sw_state_d   = sw_state_q;
        reported_d   = reported_q;
        sw_changed_d = 1'b0;
        addr_d       = addr_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        send_done    = 1'b0;
`ifdef UART_IO_SWITCH_POLLER_CRLF_EN
        beat_d       = beat_q;
`endif

        // Timer runs in every state while enabled so poll starts stay POLL_DIV apart
        if (poll_en) begin
            timer_d = expire ? TimerReload : timer_q - 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (expire) begin
                    state_d = StAddr;
                    addr_d  = AddrSw;
                end
            end
            StAddr: state_d = StWait;
            StWait: begin
                state_d = StCapture;
                addr_d  = AddrIdle;
            end
            StCapture: begin
                cand_d = sample;
                cnt_d  = cnt_upd;
                if (accept) begin
                    sw_state_d   = sample;
                    sw_changed_d = 1'b1;
                    reported_d   = 1'b1;
                    tx_data_d    = 8'h30 + 8'(sample);
                    tx_valid_d   = 1'b1;
                    state_d      = StSend;
                end else begin
                    state_d = StIdle;
                end
            end
            StSend: begin
                if (expire) begin
                    pend_d = 1'b1;
                end
                if (tx_fire) begin
`ifdef UART_IO_SWITCH_POLLER_CRLF_EN
                    if (beat_q == 2'd2) begin
                        send_done = 1'b1;
                        beat_d    = 2'd0;
                    end else begin
                        beat_d    = beat_q + 2'd1;
                        tx_data_d = (beat_q == 2'd0) ? 8'h0D : 8'h0A;
                    end
`else
                    send_done = 1'b1;
`endif
                end
                if (send_done) begin
                    tx_valid_d = 1'b0;
                    pend_d     = 1'b0;
                    // A poll that expired while stalled runs right away
                    if ((pend_q || expire) && poll_en) begin
                        state_d = StAddr;
                        addr_d  = AddrSw;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs; reset also kills any in-flight byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            timer_q      <= TimerReload;
            pend_q       <= 1'b0;
            cnt_q        <= '0;
            cand_q       <= '0;
            sw_state_q   <= '0;
            reported_q   <= 1'b0;
            sw_changed_q <= 1'b0;
            addr_q       <= AddrIdle;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
`ifdef UART_IO_SWITCH_POLLER_CRLF_EN
            beat_q       <= 2'd0;
`endif
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            pend_q       <= pend_d;
            cnt_q        <= cnt_d;
            cand_q       <= cand_d;
            sw_state_q   <= sw_state_d;
            reported_q   <= reported_d;
            sw_changed_q <= sw_changed_d;
            addr_q       <= addr_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
`ifdef UART_IO_SWITCH_POLLER_CRLF_EN
            beat_q       <= beat_d;
`endif
        end
    end

    assign pio_address = addr_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign sw_state    = sw_state_q;
    assign sw_changed  = sw_changed_q;

endmodule

// File: tb/tb_uart_io_switch_poller.sv
// Bench for uart_io_switch_poller: PIO model, window-based debounce reference model,
// byte/state scoreboard checked by an independent negedge monitor.
module tb_uart_io_switch_poller;

    localparam int unsigned POLL_DIV   = 8;
    localparam int unsigned STABLE_CNT = 2;
    localparam int unsigned SW_WIDTH   = 3;
`ifdef UART_IO_SWITCH_POLLER_CRLF_EN
    localparam int BytesPer = 3;
`else
    localparam int BytesPer = 1;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                poll_en;
    logic [1:0]          pio_address;
    logic [31:0]         pio_readdata;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic [SW_WIDTH-1:0] sw_state;
    logic                sw_changed;
    logic [2:0]          sw;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int unsigned hist[$];
    bit          rep_valid = 1'b0;
    int unsigned rep_val   = 0;
    logic [7:0]  exp_bytes[$];
    int unsigned exp_states[$];

    // Monitor bookkeeping
    int   cyc_n = 0;
    int   n_polls = 0, n_starts = 0, n_bytes = 0;
    int   last_start = 0, last_hs = 0, zero_run = 0;
    bit   have_start = 1'b0, period_chk = 1'b0, rand_phase = 1'b0;
    logic [1:0] prev_addr = 2'd3;
    logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_changed = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [SW_WIDTH-1:0] prev_sw_state = '0;

    always #5 clk = ~clk;

    uart_io_switch_poller #(
        .POLL_DIV  (POLL_DIV),
        .STABLE_CNT(STABLE_CNT),
        .SW_WIDTH  (SW_WIDTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .poll_en     (poll_en),
        .pio_address (pio_address),
        .pio_readdata(pio_readdata),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .sw_state    (sw_state),
        .sw_changed  (sw_changed)
    );

    // Switch PIO: registered readdata, junk in the upper bits, 0 at the idle address
    always @(posedge clk or posedge reset) begin
        if (reset) pio_readdata <= 32'd0;
        else if (pio_address == 2'd0) pio_readdata <= ($urandom() & 32'hFFFF_FFF8) | {29'd0, sw};
        else pio_readdata <= 32'd0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // A value is reported once the last STABLE_CNT polls all read it and it is new
    function automatic void model_poll(input int unsigned v);
        bit stable;
        hist.push_back(v);
        if (hist.size() > STABLE_CNT) void'(hist.pop_front());
        n_polls++;
        stable = (hist.size() == STABLE_CNT);
        foreach (hist[i]) if (hist[i] != v) stable = 1'b0;
        if (stable && (!rep_valid || v != rep_val)) begin
            rep_valid = 1'b1;
            rep_val   = v;
            exp_bytes.push_back(8'h30 + 8'(v));
`ifdef UART_IO_SWITCH_POLLER_CRLF_EN
            exp_bytes.push_back(8'h0D);
            exp_bytes.push_back(8'h0A);
`endif
            exp_states.push_back(v);
        end
    endfunction

    function automatic void model_reset();
        hist.delete();
        exp_bytes.delete();
        exp_states.delete();
        rep_valid = 1'b0;
        rep_val   = 0;
    endfunction

    // Monitor: watches the PIO bus and TX stream, compares against the scoreboard
    always @(negedge clk) begin
        if (reset) begin
            prev_addr = 2'd3; prev_valid = 1'b0; prev_ready = 1'b0; prev_changed = 1'b0;
            prev_sw_state = '0; have_start = 1'b0; zero_run = 0;
        end else begin
            cyc_n++;
            check("addr_legal", (pio_address == 2'd0 || pio_address == 2'd3), 1'b1);
            if (pio_address == 2'd0) zero_run++;
            if (prev_addr == 2'd3 && pio_address == 2'd0) begin
                if (period_chk && have_start) check("poll_period", cyc_n - last_start, POLL_DIV);
                last_start = cyc_n;
                have_start = 1'b1;
                n_starts++;
            end
            if (prev_addr == 2'd0 && pio_address == 2'd3) begin
                check("addr_zero_len", zero_run, 2);
                zero_run = 0;
                model_poll(pio_readdata[SW_WIDTH-1:0]);
            end
            if (prev_valid && !prev_ready) begin
                check("stall_valid", tx_valid, 1'b1);
                check("stall_data", tx_data, prev_data);
            end
            if (tx_valid && tx_ready) begin
                last_hs = cyc_n;
                n_bytes++;
                if (exp_bytes.size() == 0) begin
                    total++; bad++;
                    $display("FAIL tx_byte: got %02h required no byte (cycle %0d)", tx_data, cyc_n);
                end else begin
                    check("tx_byte", tx_data, exp_bytes.pop_front());
                end
            end
            if (sw_changed) begin
                check("changed_width", prev_changed, 1'b0);
                if (exp_states.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sw_changed: got pulse with sw_state=%0d required none", sw_state);
                end else begin
                    check("sw_state_new", sw_state, exp_states.pop_front());
                end
            end else begin
                check("sw_state_hold", sw_state, prev_sw_state);
            end
            prev_addr = pio_address; prev_valid = tx_valid; prev_ready = tx_ready;
            prev_data = tx_data; prev_changed = sw_changed; prev_sw_state = sw_state;
        end
    end

    task automatic wait_polls(input int n);
        int target;
        int budget;
        target = n_polls + n;
        budget = n * POLL_DIV * 4 + 64;
        while (n_polls < target && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (n_polls < target) begin
            total++; bad++;
            $display("FAIL wait_polls: got %0d polls required %0d", n_polls, target);
        end
    endtask

    task automatic wait_tx_valid();
        int budget;
        budget = 200;
        while (!tx_valid && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        check("tx_valid_seen", tx_valid, 1'b1);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int b0;
        int s0;
        int budget;
        reset = 1'b1; poll_en = 1'b1; tx_ready = 1'b1; sw = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr", pio_address, 2'd3);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_sw_state", sw_state, 0);
        check("rst_sw_changed", sw_changed, 1'b0);
        reset = 1'b0;

        // Switches at 0 from reset: one report, then silence while stable
        period_chk = 1'b1;
        b0 = n_bytes;
        wait_polls(12);
        check("a_byte_count", n_bytes - b0, BytesPer);
        check("a_sw_state", sw_state, 0);

        // Reset, switches at 5
        sw = 3'd5;
        apply_reset();
        b0 = n_bytes;
        wait_polls(3);
        check("b_byte_count", n_bytes - b0, BytesPer);
        check("b_sw_state", sw_state, 5);

        // One-poll glitch to 2 and back
        wait_polls(1);
        b0 = n_bytes;
        sw = 3'd2;
        wait_polls(1);
        sw = 3'd5;
        wait_polls(3);
        check("c_byte_count", n_bytes - b0, 0);
        check("c_sw_state", sw_state, 5);

        // Stalled TX with a poll expiring during the stall
        period_chk = 1'b0;
        tx_ready = 1'b0;
        sw = 3'd7;
        wait_tx_valid();
        repeat (20) begin
            @(posedge clk); #1;
            check("d_stall_valid", tx_valid, 1'b1);
            check("d_stall_data", tx_data, 8'h37);
        end
        s0 = n_starts;
        tx_ready = 1'b1;
        budget = 0;
        while (n_starts == s0 && budget < 40) begin
            @(posedge clk); #1;
            budget++;
        end
        check("d_pending_poll", n_starts - s0, 1);
        check("d_poll_after_send", last_start - last_hs, 1);

        // poll_en drop mid-WAIT: sequence finishes, then no new polls
        sw = 3'd3;
        wait_polls(1);
        budget = 0;
        while (pio_address != 2'd0 && budget < 64) begin
            @(posedge clk); #1;
            budget++;
        end
        check("e_addr_seen", pio_address, 2'd0);
        @(posedge clk); #1;
        poll_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 s0 = n_starts;
        repeat (40) @(posedge clk);
        #1;
        check("e_no_polls", n_starts - s0, 0);
        check("e_drained", exp_bytes.size(), 0);
        check("e_sw_state", sw_state, 3);
        poll_en = 1'b1;
        budget = 0;
        while (n_starts == s0 && budget < POLL_DIV + 4) begin
            @(posedge clk); #1;
            budget++;
        end
        check("e_resume", n_starts - s0, 1);

        // Reset while a byte is being offered
        tx_ready = 1'b0;
        sw = 3'd6;
        wait_tx_valid();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("f_tx_valid", tx_valid, 1'b0);
        check("f_addr", pio_address, 2'd3);
        check("f_sw_state", sw_state, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tx_ready = 1'b1;

        // Value 2 then random switches with random tx_ready
        sw = 3'd2;
        b0 = n_bytes;
        wait_polls(3);
        check("g_byte_count", n_bytes - b0, BytesPer);
        check("g_sw_state", sw_state, 2);
        rand_phase = 1'b1;
        fork
            begin
                sw = 3'd5;
                wait_polls(3);
                sw = 3'd2;
                wait_polls(3);
                for (int i = 0; i < 25; i++) begin
                    sw = 3'($urandom_range(0, 7));
                    wait_polls(int'($urandom_range(1, 3)));
                end
                rand_phase = 1'b0;
            end
            begin
                while (rand_phase) begin
                    @(posedge clk); #1;
                    tx_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        tx_ready = 1'b1;
        wait_polls(3);
        check("g_bytes_drained", exp_bytes.size(), 0);
        check("g_states_drained", exp_states.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test required end before time limit");
        $fatal(1, "time limit");
    end

endmodule
